// File: rtl/eth_rx_framer_if.sv
// Signal bundle between the MII byte assembler, eth_rx_framer and the MAC receive logic.
interface eth_rx_framer_if;
   // Strobe semantics with no backpressure: byte_d counts only in a cycle with byte_rdy
   // high, out_data/out_sof only with out_valid high, and frame_good/frame_err_*/frame_len
   // only with frame_done high. There is no ready; the sink takes every strobe.
   logic        mii_en;
   logic        byte_rdy;
   logic [7:0]  byte_d;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_sof;
   logic        frame_done;
   logic        frame_good;
   logic        frame_err_crc;
   logic        frame_err_len;
   logic [10:0] frame_len;
   logic [1:0]  dbg_state;

   modport master (
      output mii_en, byte_rdy, byte_d,
      input  out_valid, out_data, out_sof, frame_done, frame_good,
             frame_err_crc, frame_err_len, frame_len, dbg_state
   );

   modport slave (
      input  mii_en, byte_rdy, byte_d,
      output out_valid, out_data, out_sof, frame_done, frame_good,
             frame_err_crc, frame_err_len, frame_len, dbg_state
   );
endinterface

// File: rtl/eth_rx_framer.sv
// Ethernet receive framer: strips preamble/SFD, holds back the 4 FCS bytes through a
// delay line, and reports CRC-32 residue and length status at end of frame.
module eth_rx_framer #(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1518
) (
   input logic           mii_clk,
   input logic           reset,
   eth_rx_framer_if.slave bus
);

   localparam logic [10:0] L_MIN       = 11'(MIN_LEN);
   localparam logic [10:0] L_MAX       = 11'(MAX_LEN);
   localparam logic [10:0] L_SAT       = 11'd2047;
   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_PREAMBLE = 2'd1,
      S_DATA     = 2'd2,
      S_DROP     = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        w_eof;
   logic        w_sfd;
   logic        w_push;
   logic        w_done;
   logic [31:0] w_crc_nxt;
   logic        w_err_crc;
   logic        w_err_len;

   logic [31:0] r_crc;
   logic [10:0] r_len;
   logic [7:0]  r_dly [4];
   logic [2:0]  r_dly_cnt;
   logic        r_sof_pend;
   logic        r_out_valid;
   logic [7:0]  r_out_data;
   logic        r_out_sof;
   logic        r_frame_done;
   logic        r_frame_good;
   logic        r_err_crc;
   logic        r_err_len;
   logic [10:0] r_frame_len;

   // Reflected CRC-32, one byte per call, bit 0 of the byte first.
   function automatic logic [31:0] f_crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] x;
      x = c ^ {24'd0, d};
      for (int i = 0; i < 8; i++) begin
         x = x[0] ? ((x >> 1) ^ 32'hEDB8_8320) : (x >> 1);
      end
      return x;
   endfunction

   assign w_crc_nxt = f_crc_byte(r_crc, bus.byte_d);
   assign w_err_crc = (r_crc != CRC_RESIDUE);
   assign w_err_len = (r_len < L_MIN) || (r_len > L_MAX);
   // The assembler may strobe the last byte one cycle after mii_en falls, so the frame
   // only ends once both are low.
   assign w_eof     = !bus.mii_en && !bus.byte_rdy;

   always_ff @(posedge mii_clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sfd       = 1'b0;
      w_push      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.byte_rdy) w_state_nxt = (bus.byte_d == 8'h55) ? S_PREAMBLE : S_DROP;
         end
         S_PREAMBLE: begin
            if (bus.byte_rdy) begin
               if (bus.byte_d == 8'hD5) begin
                  w_state_nxt = S_DATA;
                  w_sfd       = 1'b1;
               end else if (bus.byte_d != 8'h55) begin
                  w_state_nxt = S_DROP;
               end
            end else if (w_eof) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_DATA: begin
            if (bus.byte_rdy) begin
               w_push = 1'b1;
            end else if (w_eof) begin
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_DROP: begin
            if (w_eof) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge mii_clk) begin
      if (!reset) begin
         r_crc        <= CRC_INIT;
         r_len        <= '0;
         r_dly_cnt    <= '0;
         r_sof_pend   <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_sof    <= 1'b0;
         r_frame_done <= 1'b0;
         r_frame_good <= 1'b0;
         r_err_crc    <= 1'b0;
         r_err_len    <= 1'b0;
         r_frame_len  <= '0;
         for (int i = 0; i < 4; i++) r_dly[i] <= '0;
      end else begin
         r_out_valid  <= 1'b0;
         r_out_sof    <= 1'b0;
         r_frame_done <= 1'b0;
         if (w_sfd) begin
            r_crc      <= CRC_INIT;
            r_len      <= '0;
            r_dly_cnt  <= '0;
            r_sof_pend <= 1'b1;
         end
         if (w_push) begin
            r_crc    <= w_crc_nxt;
            if (r_len != L_SAT) r_len <= r_len + 11'd1;
            r_dly[0] <= bus.byte_d;
            r_dly[1] <= r_dly[0];
            r_dly[2] <= r_dly[1];
            r_dly[3] <= r_dly[2];
            // A full line means the oldest byte can no longer be part of the FCS.
            if (r_dly_cnt == 3'd4) begin
               r_out_valid <= 1'b1;
               r_out_data  <= r_dly[3];
               r_out_sof   <= r_sof_pend;
               r_sof_pend  <= 1'b0;
            end else begin
               r_dly_cnt <= r_dly_cnt + 3'd1;
            end
         end
         if (w_done) begin
            r_frame_done <= 1'b1;
            r_err_crc    <= w_err_crc;
            r_err_len    <= w_err_len;
            r_frame_good <= !w_err_crc && !w_err_len;
            r_frame_len  <= r_len;
         end
      end
   end

   assign bus.out_valid     = r_out_valid;
   assign bus.out_data      = r_out_data;
   assign bus.out_sof       = r_out_sof;
   assign bus.frame_done    = r_frame_done;
   assign bus.frame_good    = r_frame_good;
   assign bus.frame_err_crc = r_err_crc;
   assign bus.frame_err_len = r_err_len;
   assign bus.frame_len     = r_frame_len;
   assign bus.dbg_state     = r_state;

endmodule

// File: tb/tb_eth_rx_framer.sv
// Bench for eth_rx_framer: two instances (MIN_LEN 13 and default 64) driven with the same
// byte stream; payload and status are checked against expected queues including timing.
module tb_eth_rx_framer;

   logic mii_clk;
   logic reset;

   initial mii_clk = 1'b0;
   always #5 mii_clk = ~mii_clk;

   eth_rx_framer_if if_a ();
   eth_rx_framer_if if_b ();

   eth_rx_framer #(.MIN_LEN(13)) dut_a (.mii_clk(mii_clk), .reset(reset), .bus(if_a));
   eth_rx_framer                 dut_b (.mii_clk(mii_clk), .reset(reset), .bus(if_b));

   logic        ov   [2];
   logic [7:0]  od   [2];
   logic        osof [2];
   logic        fd   [2];
   logic        fg   [2];
   logic        fec  [2];
   logic        fel  [2];
   logic [10:0] flen [2];
   logic [1:0]  ds   [2];

   assign ov[0] = if_a.out_valid;      assign ov[1] = if_b.out_valid;
   assign od[0] = if_a.out_data;       assign od[1] = if_b.out_data;
   assign osof[0] = if_a.out_sof;      assign osof[1] = if_b.out_sof;
   assign fd[0] = if_a.frame_done;     assign fd[1] = if_b.frame_done;
   assign fg[0] = if_a.frame_good;     assign fg[1] = if_b.frame_good;
   assign fec[0] = if_a.frame_err_crc; assign fec[1] = if_b.frame_err_crc;
   assign fel[0] = if_a.frame_err_len; assign fel[1] = if_b.frame_err_len;
   assign flen[0] = if_a.frame_len;    assign flen[1] = if_b.frame_len;
   assign ds[0] = if_a.dbg_state;      assign ds[1] = if_b.dbg_state;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int min_len [2] = '{13, 64};

   // Expected payload: {cycle, sof, data}; expected status: {cycle, good, err_crc, err_len, len}.
   logic [40:0] pay_q [2][$];
   logic [45:0] st_q  [2][$];

   logic [7:0] fb [0:2047];
   int         fn;

   function automatic logic [31:0] crc_calc(input int n);
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < n; i++) begin
         c = c ^ {24'd0, fb[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return c;
   endfunction

   // One cycle: sample and score the outputs at the falling edge, then drive new inputs.
   task automatic tick(input logic rst_v, input logic en, input logic rdy, input logic [7:0] d);
      logic [40:0] pe;
      logic [45:0] se;
      @(negedge mii_clk);
      cyc++;
      for (int g = 0; g < 2; g++) begin
         if (ov[g] === 1'b1) begin
            n_checks++;
            if (pay_q[g].size() == 0) begin
               $display("FAIL payload_unexpected dut%0d cyc %0d: got data %h sof %b, expected none",
                        g, cyc, od[g], osof[g]);
            end else begin
               pe = pay_q[g].pop_front();
               if ({32'(cyc), osof[g], od[g]} !== pe)
                  $display("FAIL payload dut%0d: got cyc %0d sof %b data %h, expected cyc %0d sof %b data %h",
                           g, cyc, osof[g], od[g], pe[40:9], pe[8], pe[7:0]);
               else n_pass++;
            end
         end else if (pay_q[g].size() > 0 && pay_q[g][0][40:9] <= 32'(cyc)) begin
            n_checks++;
            pe = pay_q[g].pop_front();
            $display("FAIL payload_missing dut%0d: got no out_valid at cyc %0d, expected data %h",
                     g, cyc, pe[7:0]);
         end
         if (fd[g] === 1'b1) begin
            n_checks++;
            if (ov[g] !== 1'b0)
               $display("FAIL valid_with_done dut%0d cyc %0d: got out_valid %b, expected 0", g, cyc, ov[g]);
            else n_pass++;
            n_checks++;
            if (st_q[g].size() == 0) begin
               $display("FAIL done_unexpected dut%0d cyc %0d: got frame_done, expected none", g, cyc);
            end else begin
               se = st_q[g].pop_front();
               if ({32'(cyc), fg[g], fec[g], fel[g], flen[g]} !== se)
                  $display("FAIL status dut%0d: got cyc %0d g/c/l %b%b%b len %0d, expected cyc %0d g/c/l %b%b%b len %0d",
                           g, cyc, fg[g], fec[g], fel[g], flen[g],
                           se[45:14], se[13], se[12], se[11], se[10:0]);
               else n_pass++;
            end
         end else if (st_q[g].size() > 0 && st_q[g][0][45:14] <= 32'(cyc)) begin
            n_checks++;
            se = st_q[g].pop_front();
            $display("FAIL done_missing dut%0d: got no frame_done at cyc %0d, expected len %0d",
                     g, cyc, se[10:0]);
         end
      end
      reset         = rst_v;
      if_a.mii_en   = en;  if_b.mii_en   = en;
      if_a.byte_rdy = rdy; if_b.byte_rdy = rdy;
      if_a.byte_d   = d;   if_b.byte_d   = d;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, 8'h00);
   endtask

   // Random payload of n-4 bytes followed by its FCS, least significant byte first.
   task automatic make_frame(input int n);
      logic [31:0] fcs;
      for (int i = 0; i < n - 4; i++) fb[i] = 8'($urandom_range(0, 255));
      fcs = ~crc_calc(n - 4);
      fb[n-4] = fcs[7:0];
      fb[n-3] = fcs[15:8];
      fb[n-2] = fcs[23:16];
      fb[n-1] = fcs[31:24];
      fn = n;
   endtask

   task automatic load_vector();
      logic [7:0] v [13];
      v = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h26, 8'h39, 8'hF4, 8'hCB};
      for (int i = 0; i < 13; i++) fb[i] = v[i];
      fn = 13;
   endtask

   // Bytes every other cycle; the last byte strobes with mii_en already low.
   task automatic send_frame(input int n_pre, input int abort_after);
      logic        crc_e;
      logic        len_e;
      logic [10:0] len;
      for (int i = 0; i < n_pre; i++) begin
         tick(1'b1, 1'b1, 1'b1, 8'h55);
         tick(1'b1, 1'b1, 1'b0, 8'h00);
      end
      tick(1'b1, 1'b1, 1'b1, 8'hD5);
      tick(1'b1, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < fn; i++) begin
         if (i == abort_after) return;
         tick(1'b1, logic'(i != fn - 1), 1'b1, fb[i]);
         if (i >= 4) begin
            for (int g = 0; g < 2; g++) pay_q[g].push_back({32'(cyc + 1), logic'(i == 4), fb[i-4]});
         end
         if (i != fn - 1) tick(1'b1, 1'b1, 1'b0, 8'h00);
      end
      tick(1'b1, 1'b0, 1'b0, 8'h00);
      if (fn >= 4) crc_e = ({fb[fn-1], fb[fn-2], fb[fn-3], fb[fn-4]} !== ~crc_calc(fn - 4));
      else         crc_e = (crc_calc(fn) !== 32'hDEBB_20E3);
      len = (fn > 2047) ? 11'd2047 : 11'(fn);
      for (int g = 0; g < 2; g++) begin
         len_e = (fn < min_len[g]) || (fn > 1518);
         st_q[g].push_back({32'(cyc + 1), !(crc_e || len_e), crc_e, len_e, len});
      end
   endtask

   task automatic test_reset();
      tick(1'b0, 1'b0, 1'b0, 8'h00);
      tick(1'b0, 1'b0, 1'b0, 8'h00);
      for (int g = 0; g < 2; g++) begin
         n_checks++;
         if ({ov[g], osof[g], fd[g], fg[g], fec[g], fel[g], od[g], flen[g]} !== 25'd0)
            $display("FAIL reset_outputs dut%0d: got %b, expected all zero",
                     g, {ov[g], osof[g], fd[g], fg[g], fec[g], fel[g], od[g], flen[g]});
         else n_pass++;
         n_checks++;
         if (ds[g] !== 2'd0) $display("FAIL reset_state dut%0d: got %0d, expected 0", g, ds[g]);
         else n_pass++;
      end
      idle(2);
   endtask

   task automatic test_known_vector();
      load_vector();
      send_frame(7, -1);
      idle(4);
      n_checks++;
      if ({fg[0], fec[0], fel[0], flen[0]} !== {3'b100, 11'd13})
         $display("FAIL vector_min13: got g/c/l %b%b%b len %0d, expected 100 len 13", fg[0], fec[0], fel[0], flen[0]);
      else n_pass++;
      n_checks++;
      if ({fg[1], fec[1], fel[1], flen[1]} !== {3'b001, 11'd13})
         $display("FAIL vector_min64: got g/c/l %b%b%b len %0d, expected 001 len 13", fg[1], fec[1], fel[1], flen[1]);
      else n_pass++;
   endtask

   task automatic test_bad_crc();
      load_vector();
      fb[12] = 8'hCA;
      send_frame(7, -1);
      idle(4);
      for (int g = 0; g < 2; g++) begin
         n_checks++;
         if ({fg[g], fec[g]} !== 2'b01)
            $display("FAIL bad_crc dut%0d: got good %b err_crc %b, expected good 0 err_crc 1", g, fg[g], fec[g]);
         else n_pass++;
      end
   endtask

   task automatic test_drop();
      logic [7:0] tail [8];
      tail = '{8'h55, 8'hD5, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
      tick(1'b1, 1'b1, 1'b1, 8'h55); tick(1'b1, 1'b1, 1'b0, 8'h00);
      tick(1'b1, 1'b1, 1'b1, 8'h55); tick(1'b1, 1'b1, 1'b0, 8'h00);
      tick(1'b1, 1'b1, 1'b1, 8'h12); tick(1'b1, 1'b1, 1'b0, 8'h00);
      for (int g = 0; g < 2; g++) begin
         n_checks++;
         if (ds[g] !== 2'd3) $display("FAIL drop_state dut%0d: got %0d, expected 3", g, ds[g]);
         else n_pass++;
      end
      for (int i = 0; i < 8; i++) begin
         tick(1'b1, logic'(i != 7), 1'b1, tail[i]);
         if (i != 7) tick(1'b1, 1'b1, 1'b0, 8'h00);
      end
      tick(1'b1, 1'b0, 1'b0, 8'h00);
      idle(4);
      load_vector();
      send_frame(7, -1);
      idle(4);
      n_checks++;
      if ({fg[0], flen[0]} !== {1'b1, 11'd13})
         $display("FAIL after_drop: got good %b len %0d, expected good 1 len 13", fg[0], flen[0]);
      else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      make_frame(64);
      send_frame(7, 20);
      tick(1'b0, 1'b1, 1'b0, 8'h00);
      tick(1'b1, 1'b0, 1'b0, 8'h00);
      for (int g = 0; g < 2; g++) begin
         n_checks++;
         if ({ov[g], fd[g], fg[g], fec[g], fel[g], od[g], flen[g]} !== 24'd0 || ds[g] !== 2'd0)
            $display("FAIL mid_reset dut%0d: got outputs %b state %0d, expected zero state 0",
                     g, {ov[g], fd[g], fg[g], fec[g], fel[g], od[g], flen[g]}, ds[g]);
         else n_pass++;
      end
      idle(6);
      make_frame(64);
      send_frame(7, -1);
      idle(4);
      for (int g = 0; g < 2; g++) begin
         n_checks++;
         if ({fg[g], flen[g]} !== {1'b1, 11'd64})
            $display("FAIL after_reset dut%0d: got good %b len %0d, expected good 1 len 64", g, fg[g], flen[g]);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      make_frame(64);
      send_frame(7, -1);
      make_frame(70);
      send_frame(3, -1);
      idle(4);
      n_checks++;
      if ({fg[1], flen[1]} !== {1'b1, 11'd70})
         $display("FAIL back_to_back: got good %b len %0d, expected good 1 len 70", fg[1], flen[1]);
      else n_pass++;
   endtask

   task automatic test_len_bounds();
      int sizes [4];
      sizes = '{3, 63, 1518, 1519};
      for (int s = 0; s < 4; s++) begin
         if (s == 0) begin
            fb[0] = 8'h00; fb[1] = 8'h11; fb[2] = 8'h22; fn = 3;
         end else begin
            make_frame(sizes[s]);
         end
         send_frame(7, -1);
         idle(4);
      end
      n_checks++;
      if ({fel[0], fel[1], flen[1]} !== {2'b11, 11'd1519})
         $display("FAIL max_len: got err_len %b%b len %0d, expected 11 len 1519", fel[0], fel[1], flen[1]);
      else n_pass++;
   endtask

   initial begin
      reset = 1'b0;
      if_a.mii_en = 1'b0; if_a.byte_rdy = 1'b0; if_a.byte_d = 8'h00;
      if_b.mii_en = 1'b0; if_b.byte_rdy = 1'b0; if_b.byte_d = 8'h00;
      test_reset();
      test_known_vector();
      test_bad_crc();
      test_drop();
      test_reset_mid_frame();
      test_back_to_back();
      test_len_bounds();
      idle(4);
      for (int g = 0; g < 2; g++) begin
         n_checks++;
         if (pay_q[g].size() != 0 || st_q[g].size() != 0)
            $display("FAIL leftover dut%0d: got %0d payload and %0d status pending, expected 0 and 0",
                     g, pay_q[g].size(), st_q[g].size());
         else n_pass++;
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
